// File: rtl/i2c_reg_target_if.sv
// i2c_reg_target_if: pin-level I2C bus plus the write-strobe export of the register target.
interface i2c_reg_target_if;
    logic       I2C_SCL;
    logic       I2C_SDA_IN;
    logic       I2C_SDA_OE;
    logic       BUSY;
    logic       WR_STB;
    logic [7:0] WR_ADDR;
    logic [7:0] WR_DATA;
    modport master (
        output I2C_SCL, I2C_SDA_IN,
        input  I2C_SDA_OE, BUSY, WR_STB, WR_ADDR, WR_DATA
    );
    modport slave (
        input  I2C_SCL, I2C_SDA_IN,
        output I2C_SDA_OE, BUSY, WR_STB, WR_ADDR, WR_DATA
    );
endinterface

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: oversampling I2C target with an 8-bit register file and write-strobe export.
// Pin events act 3 clocks after the pin changes; SCL is never stretched.
module i2c_reg_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter int         REG_COUNT = 256
) (
    input logic             CLK_50MHZ,
    input logic             RESET,
    i2c_reg_target_if.slave bus
);
    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    typedef enum logic [3:0] {IDLE, ADDR, ACK, PTR, WDATA, RDATA, MACK, MWAIT, IGNORE} state_t;

    state_t        state_q, state_d, ret_q, ret_d;
    logic [2:0]    scl_q, sda_q;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ackd_q, ackd_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          stb_q, stb_d;
    logic [7:0]    waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we;
    logic [7:0]    mem_q [REG_COUNT];

    // [0]/[1] are the synchroniser flops, [2] is the edge-detect history
    wire       scl_rise = scl_q[1] & ~scl_q[2];
    wire       scl_fall = ~scl_q[1] & scl_q[2];
    wire       start    = ~sda_q[1] & sda_q[2] & scl_q[1];
    wire       stop     = sda_q[1] & ~sda_q[2] & scl_q[1];
    wire [7:0] byte_in  = {sh_q[6:0], sda_q[1]};
    wire [7:0] rd_data  = mem_q[ptr_q];

    always_ff @(posedge CLK_50MHZ or posedge RESET) begin
        if (RESET) begin
            scl_q   <= '1;
            sda_q   <= '1;
            state_q <= IDLE;
            ret_q   <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            ptr_q   <= '0;
            ackd_q  <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
        end else begin
            scl_q   <= {scl_q[1:0], bus.I2C_SCL};
            sda_q   <= {sda_q[1:0], bus.I2C_SDA_IN};
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ptr_q   <= ptr_d;
            ackd_q  <= ackd_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            if (we) mem_q[ptr_q] <= byte_in;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        ackd_d  = ackd_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        stb_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we      = 1'b0;
        if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
            busy_d  = 1'b1;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: if (scl_rise) begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        ackd_d  = 1'b0;
                        state_d = ACK;
                        ret_d   = WDATA;
                        case (state_q)
                            ADDR: begin
                                ret_d   = byte_in[0] ? RDATA : PTR;
                                state_d = (byte_in[7:1] == DEV_ADDR) ? ACK : IGNORE;
                            end
                            PTR: ptr_d = byte_in[AW-1:0];
                            default: begin
                                we      = 1'b1;
                                stb_d   = 1'b1;
                                waddr_d = 8'(ptr_q);
                                wdata_d = byte_in;
                                ptr_d   = ptr_q + 1'b1;
                            end
                        endcase
                    end
                end
                // first falling edge drives the ACK, the second releases it and moves on
                ACK: if (scl_fall) begin
                    if (!ackd_q) begin
                        oe_d   = 1'b1;
                        ackd_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = ret_q;
                        sh_d    = (ret_q == RDATA) ? rd_data : sh_q;
                        oe_d    = (ret_q == RDATA) ? ~rd_data[7] : 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise) cnt_d = cnt_q + 4'd1;
                    else if (scl_fall) begin
                        state_d = (cnt_q == 4'd8) ? MACK : RDATA;
                        oe_d    = (cnt_q == 4'd8) ? 1'b0 : ~sh_q[6];
                        sh_d    = {sh_q[6:0], 1'b0};
                    end
                end
                MACK: if (scl_rise) begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = sda_q[1] ? IGNORE : MWAIT;
                end
                MWAIT: if (scl_fall) begin
                    state_d = RDATA;
                    cnt_d   = '0;
                    sh_d    = rd_data;
                    oe_d    = ~rd_data[7];
                end
                default: ;
            endcase
        end
    end

    assign bus.I2C_SDA_OE = oe_q;
    assign bus.BUSY       = busy_q;
    assign bus.WR_STB     = stb_q;
    assign bus.WR_ADDR    = waddr_q;
    assign bus.WR_DATA    = wdata_q;
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: bit-banged I2C master against a register-file model of the target.
module tb_i2c_reg_target;
    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    always #10 clk = ~clk;

    i2c_reg_target_if bus();
    assign bus.I2C_SCL    = m_scl;
    assign bus.I2C_SDA_IN = m_sda & ~bus.I2C_SDA_OE;

    i2c_reg_target dut (.CLK_50MHZ(clk), .RESET(rst), .bus(bus));

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [256];
    int         ptr = 0;
    logic [15:0] wq[$], exp_wq[$];
    logic [7:0]  rdq[$], exp_rd[$], none[$];
    logic       watch_oe = 1'b0;
    logic       oe_seen = 1'b0;
    logic       prev_oe = 1'b0;
    logic       prev_scl = 1'b1;

    always @(negedge clk) begin
        if (bus.WR_STB === 1'b1) wq.push_back({bus.WR_ADDR, bus.WR_DATA});
        if (watch_oe && bus.I2C_SDA_OE !== 1'b0) oe_seen = 1'b1;
    end

    always @(posedge clk) begin
        if (!rst && prev_scl && bus.I2C_SDA_OE !== prev_oe) begin
            errors++;
            $display("FAIL sda_stable: OE went %b -> %b while SCL high", prev_oe, bus.I2C_SDA_OE);
        end
        prev_oe  <= bus.I2C_SDA_OE;
        prev_scl <= m_scl;
    end

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_c();
        m_sda = 1'b1; qw();
        m_scl = 1'b1; qw();
        m_sda = 1'b0; qw();
        m_scl = 1'b0; qw();
    endtask

    task automatic stop_c();
        m_sda = 1'b0; qw();
        m_scl = 1'b1; qw();
        m_sda = 1'b1; qw(); qw();
    endtask

    task automatic wbit(input logic b);
        m_sda = b; qw();
        m_scl = 1'b1; qw(); qw();
        m_scl = 1'b0; qw();
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; qw();
        m_scl = 1'b1; qw();
        b = bus.I2C_SDA_IN; qw();
        m_scl = 1'b0; qw();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(output logic [7:0] d, input logic nk);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nk);
    endtask

    task automatic do_write(input logic [7:0] p, input logic [7:0] d[$], input bit stp, output int nak);
        logic a;
        nak = 0;
        start_c();
        wbyte(8'h72, a); if (!a) nak++;
        wbyte(p, a);     if (!a) nak++;
        ptr = int'(p);
        foreach (d[i]) begin
            wbyte(d[i], a); if (!a) nak++;
            exp_wq.push_back({8'(ptr), d[i]});
            mem[ptr] = d[i];
            ptr = (ptr + 1) % 256;
        end
        if (stp) stop_c();
    endtask

    task automatic do_read(input int n, output int nak);
        logic a;
        logic [7:0] x;
        nak = 0;
        start_c();
        wbyte(8'h73, a); if (!a) nak++;
        for (int i = 0; i < n; i++) begin
            rbyte(x, i == n - 1);
            rdq.push_back(x);
            exp_rd.push_back(mem[ptr]);
            ptr = (ptr + 1) % 256;
        end
        stop_c();
    endtask

    task automatic clear_q();
        wq.delete(); exp_wq.delete(); rdq.delete(); exp_rd.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus.I2C_SDA_OE !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", bus.I2C_SDA_OE); end
        if (bus.BUSY !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        if (bus.WR_STB !== 1'b0)     begin errors++; $display("FAIL reset_stb: got %b want 0", bus.WR_STB); end
        if (bus.WR_ADDR !== 8'h00)   begin errors++; $display("FAIL reset_waddr: got %h want 00", bus.WR_ADDR); end
        if (bus.WR_DATA !== 8'h00)   begin errors++; $display("FAIL reset_wdata: got %h want 00", bus.WR_DATA); end
        rst = 1'b0;
        qw();
    endtask

    task automatic test_write();
        int nak;
        clear_q();
        do_write(8'h41, '{8'h10}, 0, nak);
        checks++; if (nak != 0) begin errors++; $display("FAIL write_ack: got %0d NAKs want 0", nak); end
        m_sda = 1'b0; qw();
        m_scl = 1'b1; qw();
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL write_busy_high: got %b want 1", bus.BUSY); end
        m_sda = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL busy_early_fall: got %b want 1", bus.BUSY); end
        @(negedge clk);
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL busy_fall_3cyc: got %b want 0", bus.BUSY); end
        qw();
        checks++;
        if (wq.size() != 1 || exp_wq.size() != 1) begin errors++; $display("FAIL write_stb_count: got %0d want 1", wq.size()); end
        else if (wq[0] !== exp_wq[0]) begin errors++; $display("FAIL write_stb: got %h want %h", wq[0], exp_wq[0]); end
    endtask

    task automatic test_burst_wrap();
        int nak;
        clear_q();
        do_write(8'hFE, '{8'hAA, 8'hBB, 8'hCC}, 1, nak);
        checks++; if (nak != 0) begin errors++; $display("FAIL burst_ack: got %0d NAKs want 0", nak); end
        checks++;
        if (wq.size() != exp_wq.size()) begin errors++; $display("FAIL burst_stb_count: got %0d want %0d", wq.size(), exp_wq.size()); end
        else for (int i = 0; i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== exp_wq[i]) begin errors++; $display("FAIL burst_stb%0d: got %h want %h", i, wq[i], exp_wq[i]); end
        end
        do_write(8'h00, none, 0, nak);
        do_read(1, nak);
        checks++; if (rdq[0] !== exp_rd[0]) begin errors++; $display("FAIL burst_readback: got %h want %h", rdq[0], exp_rd[0]); end
    endtask

    task automatic test_wrong_addr();
        logic a;
        int   nak = 0;
        clear_q();
        oe_seen = 1'b0;
        watch_oe = 1'b1;
        start_c();
        wbyte(8'h74, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrong_addr_nak: got ack %b want 0", a); end
        wbyte(8'($urandom), a); if (a) nak++;
        wbyte(8'($urandom), a); if (a) nak++;
        checks++; if (nak != 0) begin errors++; $display("FAIL wrong_addr_data_ack: got %0d ACKs want 0", nak); end
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL wrong_addr_busy: got %b want 1", bus.BUSY); end
        stop_c();
        watch_oe = 1'b0;
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL wrong_addr_oe: got %b want 0", oe_seen); end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL wrong_addr_stb: got %0d want 0", wq.size()); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy_end: got %b want 0", bus.BUSY); end
    endtask

    task automatic test_read_rep_start();
        int         nak;
        logic       a;
        logic [7:0] x0, x1, e0, e1;
        clear_q();
        do_write(8'h43, '{8'($urandom_range(1, 255))}, 1, nak);
        do_write(8'h41, none, 0, nak);
        start_c();
        wbyte(8'h73, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL read_addr_ack: got %b want 1", a); end
        e0 = mem[ptr]; ptr = (ptr + 1) % 256;
        e1 = mem[ptr]; ptr = (ptr + 1) % 256;
        rbyte(x0, 1'b0);
        rbyte(x1, 1'b1);
        oe_seen = 1'b0;
        watch_oe = 1'b1;
        qw(); m_scl = 1'b1; qw(); m_scl = 1'b0; qw();
        watch_oe = 1'b0;
        stop_c();
        checks += 3;
        if (x0 !== e0) begin errors++; $display("FAIL read_byte0: got %h want %h", x0, e0); end
        if (x1 !== e1) begin errors++; $display("FAIL read_byte1: got %h want %h", x1, e1); end
        if (oe_seen !== 1'b0) begin errors++; $display("FAIL read_after_nack_oe: got %b want 0", oe_seen); end
        do_read(1, nak);
        checks++; if (rdq[0] !== exp_rd[0]) begin errors++; $display("FAIL read_ptr_end: got %h want %h", rdq[0], exp_rd[0]); end
    endtask

    task automatic test_abort_stop();
        int   nak;
        logic a;
        clear_q();
        start_c();
        wbyte(8'h72, a);
        wbyte(8'h20, a);
        for (int i = 0; i < 4; i++) wbit(1'($urandom));
        stop_c();
        checks += 3;
        if (wq.size() != 0)        begin errors++; $display("FAIL abort_stb: got %0d want 0", wq.size()); end
        if (bus.BUSY !== 1'b0)     begin errors++; $display("FAIL abort_busy: got %b want 0", bus.BUSY); end
        if (bus.I2C_SDA_OE !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b want 0", bus.I2C_SDA_OE); end
        do_write(8'h20, '{8'($urandom)}, 1, nak);
        checks += 2;
        if (nak != 0) begin errors++; $display("FAIL abort_rewrite_ack: got %0d NAKs want 0", nak); end
        if (wq.size() != 1 || wq[0] !== exp_wq[0]) begin errors++; $display("FAIL abort_rewrite_stb: got %0d strobes want 1 of %h", wq.size(), exp_wq[0]); end
        do_write(8'h20, none, 0, nak);
        do_read(1, nak);
        checks++; if (rdq[0] !== exp_rd[0]) begin errors++; $display("FAIL abort_readback: got %h want %h", rdq[0], exp_rd[0]); end
    endtask

    task automatic test_random();
        int         nak, n;
        logic [7:0] p;
        logic [7:0] d[$];
        for (int t = 0; t < 4; t++) begin
            clear_q();
            d.delete();
            p = 8'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            do_write(p, d, 1, nak);
            checks++; if (nak != 0) begin errors++; $display("FAIL rnd%0d_ack: got %0d NAKs want 0", t, nak); end
            checks++;
            if (wq.size() != exp_wq.size()) begin errors++; $display("FAIL rnd%0d_stb_count: got %0d want %0d", t, wq.size(), exp_wq.size()); end
            else for (int i = 0; i < wq.size(); i++) begin
                checks++;
                if (wq[i] !== exp_wq[i]) begin errors++; $display("FAIL rnd%0d_stb%0d: got %h want %h", t, i, wq[i], exp_wq[i]); end
            end
            do_write(p, none, 0, nak);
            do_read(n, nak);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rdq[i] !== exp_rd[i]) begin errors++; $display("FAIL rnd%0d_read%0d: got %h want %h", t, i, rdq[i], exp_rd[i]); end
            end
        end
    endtask

    task automatic test_reset_during_ack();
        int   nak;
        logic [7:0] ad = 8'h72;
        clear_q();
        start_c();
        for (int i = 7; i >= 0; i--) wbit(ad[i]);
        m_sda = 1'b1;
        checks++; if (bus.I2C_SDA_OE !== 1'b1) begin errors++; $display("FAIL rstack_oe_before: got %b want 1", bus.I2C_SDA_OE); end
        rst = 1'b1;
        #1;
        checks += 2;
        if (bus.I2C_SDA_OE !== 1'b0) begin errors++; $display("FAIL rstack_oe_async: got %b want 0", bus.I2C_SDA_OE); end
        if (bus.BUSY !== 1'b0)       begin errors++; $display("FAIL rstack_busy_async: got %b want 0", bus.BUSY); end
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ptr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_scl = 1'b1;
        qw(); qw();
        do_read(2, nak);
        do_write(8'h41, none, 0, nak);
        do_read(1, nak);
        do_write(8'h43, none, 0, nak);
        do_read(1, nak);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdq[i] !== exp_rd[i]) begin errors++; $display("FAIL rstack_read%0d: got %h want %h", i, rdq[i], exp_rd[i]); end
        end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL rstack_stb: got %0d want 0", wq.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_write();
        test_burst_wrap();
        test_wrong_addr();
        test_read_rep_start();
        test_abort_stop();
        test_random();
        test_reset_during_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
